// File: rtl/startup_sequencer.sv
// Power-on startup sequencer: raises CH_NUM start enables one after another,
// each after its own programmable delay, with reverse shutdown and restart.
module startup_sequencer #(
  parameter int                        CH_NUM  = 4,
  parameter int                        CNT_W   = 16,
  parameter logic [CH_NUM*CNT_W-1:0]   DELAY   = {16'd100, 16'd100, 16'd200, 16'd50},
  parameter int                        OFF_GAP = 25
) (
  input  logic              i_clk_50,
  input  logic              i_rst_n,
  input  logic              i_stop,
  input  logic              i_restart,
  output logic [CH_NUM-1:0] o_start,
  output logic              o_all_on,
  output logic              o_busy,
  output logic              o_off
);

  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  localparam logic [1:0] ST_WAIT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;
  localparam logic [1:0] ST_OFF  = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_NUM - 1);
  localparam logic [CNT_W-1:0] GAP_TGT  = CNT_W'(OFF_GAP - 1);

  if (CH_NUM < 1 || CH_NUM > 16) begin : g_bad_ch_num
    $error("startup_sequencer: CH_NUM must be in 1..16");
  end
  if (OFF_GAP < 1 || OFF_GAP > (2 ** CNT_W)) begin : g_bad_off_gap
    $error("startup_sequencer: OFF_GAP must be >= 1 and fit the counter");
  end

  // Each channel's terminal count; a programmed delay of 0 behaves as 1.
  logic [CNT_W-1:0] w_tgt_tab [CH_NUM];
  for (genvar g = 0; g < CH_NUM; g++) begin : g_tgt
    localparam int               DV = int'(DELAY[g*CNT_W +: CNT_W]);
    localparam logic [CNT_W-1:0] TG = CNT_W'((DV == 0) ? 0 : DV - 1);
    assign w_tgt_tab[g] = TG;
  end

  // Clears the most significant set bit of a channel vector.
  function automatic logic [CH_NUM-1:0] clr_top(input logic [CH_NUM-1:0] v);
    logic [CH_NUM-1:0] r;
    logic              done;
    r    = v;
    done = 1'b0;
    for (int k = CH_NUM - 1; k >= 0; k--) begin
      if (!done && v[k]) begin
        r[k] = 1'b0;
        done = 1'b1;
      end else begin
        done = done;
      end
    end
    return r;
  endfunction

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [CH_NUM-1:0] r_start;
  logic              r_all_on;
  logic              r_busy;
  logic              r_off;

  logic [1:0]        w_state_n;
  logic [IDX_W-1:0]  w_idx_n;
  logic [CNT_W-1:0]  w_cnt_n;
  logic [CH_NUM-1:0] w_start_n;
  logic [CH_NUM-1:0] w_drop;
  logic [CNT_W-1:0]  w_tgt;

  // Next-state logic: stop beats restart in WAIT/RUN, restart beats stop in OFF.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_cnt_n   = r_cnt;
    w_start_n = r_start;
    w_drop    = clr_top(r_start);
    w_tgt     = w_tgt_tab[r_idx];
    case (r_state)
      ST_WAIT, ST_RUN: begin
        if (i_stop) begin
          w_start_n = w_drop;
          w_cnt_n   = '0;
          w_idx_n   = '0;
          w_state_n = (w_drop == '0) ? ST_OFF : ST_STOP;
        end else if (r_state == ST_WAIT) begin
          if (r_cnt == w_tgt) begin
            w_start_n[r_idx] = 1'b1;
            w_cnt_n          = '0;
            if (r_idx == IDX_LAST) begin
              w_state_n = ST_RUN;
            end else begin
              w_idx_n = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end else begin
          w_state_n = ST_RUN;
        end
      end
      ST_STOP: begin
        if (r_cnt == GAP_TGT) begin
          w_start_n = w_drop;
          w_cnt_n   = '0;
          w_state_n = (w_drop == '0) ? ST_OFF : ST_STOP;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end
      ST_OFF: begin
        w_start_n = '0;
        if (i_restart) begin
          w_state_n = ST_WAIT;
          w_idx_n   = '0;
          w_cnt_n   = '0;
        end else begin
          w_state_n = ST_OFF;
        end
      end
      default: begin
        w_state_n = ST_WAIT;
        w_idx_n   = '0;
        w_cnt_n   = '0;
        w_start_n = '0;
      end
    endcase
  end

  // State and registered outputs; flags follow the same edge as o_start.
  always_ff @(posedge i_clk_50 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_WAIT;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_start  <= '0;
      r_all_on <= 1'b0;
      r_busy   <= 1'b1;
      r_off    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_idx    <= w_idx_n;
      r_cnt    <= w_cnt_n;
      r_start  <= w_start_n;
      r_all_on <= (w_state_n == ST_RUN);
      r_busy   <= (w_state_n == ST_WAIT) || (w_state_n == ST_STOP);
      r_off    <= (w_state_n == ST_OFF);
    end
  end

  assign o_start  = r_start;
  assign o_all_on = r_all_on;
  assign o_busy   = r_busy;
  assign o_off    = r_off;

endmodule

// File: tb/tb_startup_sequencer.sv
// Bench for startup_sequencer: timeline model for the default instance plus
// literal checks on a 2-channel and a zero-delay-channel instance.
module tb_startup_sequencer;

  localparam int CH  = 4;
  localparam int GAP = 25;
  localparam int D [CH] = '{50, 200, 100, 100};

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic stop0    = 1'b0;
  logic restart0 = 1'b0;
  logic stop2    = 1'b0;
  logic restart2 = 1'b0;
  logic tie0     = 1'b0;

  logic [3:0] st0;
  logic       on0, busy0, off0;
  logic [1:0] st1;
  logic       on1, busy1, off1;
  logic [3:0] st2;
  logic       on2, busy2, off2;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: edges since release, power-up origin, last stop edge and count.
  int cyc  = 0;
  int t0   = 0;
  int s_e  = 0;
  int n_on = 0;
  bit m_up = 1'b1;

  always #5 clk = ~clk;

  startup_sequencer dut0 (
    .i_clk_50(clk), .i_rst_n(rst_n), .i_stop(stop0), .i_restart(restart0),
    .o_start(st0), .o_all_on(on0), .o_busy(busy0), .o_off(off0)
  );

  startup_sequencer #(
    .CH_NUM(2), .CNT_W(16), .DELAY({16'd200, 16'd50}), .OFF_GAP(25)
  ) dut1 (
    .i_clk_50(clk), .i_rst_n(rst_n), .i_stop(tie0), .i_restart(tie0),
    .o_start(st1), .o_all_on(on1), .o_busy(busy1), .o_off(off1)
  );

  startup_sequencer #(
    .CH_NUM(4), .CNT_W(16), .DELAY({16'd10, 16'd0, 16'd20, 16'd5}), .OFF_GAP(3)
  ) dut2 (
    .i_clk_50(clk), .i_rst_n(rst_n), .i_stop(stop2), .i_restart(restart2),
    .o_start(st2), .o_all_on(on2), .o_busy(busy2), .o_off(off2)
  );

  function automatic int on_cnt(input int t);
    int c;
    int acc;
    c   = 0;
    acc = 0;
    for (int k = 0; k < CH; k++) begin
      acc += (D[k] < 1) ? 1 : D[k];
      if (t - t0 >= acc) c++;
    end
    return c;
  endfunction

  function automatic int rem(input int t);
    int r;
    r = n_on - 1 - (t - s_e) / GAP;
    return (r < 0) ? 0 : r;
  endfunction

  function automatic logic [7:0] expv();
    int         c;
    logic [3:0] b;
    if (!rst_n) return 8'b0000_0010;
    if (m_up) begin
      c = on_cnt(cyc);
      b = 4'((1 << c) - 1);
      return {1'b0, b, (c == CH), (c < CH), 1'b0};
    end
    c = rem(cyc);
    b = 4'((1 << c) - 1);
    return {1'b0, b, 1'b0, (c > 0), (c == 0)};
  endfunction

  function automatic logic [7:0] pk4(input logic [3:0] s, input logic a, input logic b, input logic o);
    return {1'b0, s, a, b, o};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= 0;
      t0   <= 0;
      s_e  <= 0;
      n_on <= 0;
      m_up <= 1'b1;
    end else begin
      cyc <= cyc + 1;
      if (m_up && stop0) begin
        m_up <= 1'b0;
        s_e  <= cyc + 1;
        n_on <= on_cnt(cyc);
      end else if (!m_up && rem(cyc) == 0 && restart0) begin
        m_up <= 1'b1;
        t0   <= cyc + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [7:0] e;
    logic [7:0] a;
    e = expv();
    a = pk4(st0, on0, busy0, off0);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL model cyc=%0d: got start=%b all_on=%b busy=%b off=%b, expected start=%b all_on=%b busy=%b off=%b",
               cyc, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0]);
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cyc %0d): got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    while (cyc < c && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != c) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_cyc: reached %0d expected %0d", cyc, c);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_vals", pk4(st0, on0, busy0, off0), 8'b0000_0010);
    rst_n = 1'b1;

    wait_cyc(5);  chk("d2_ch0",    pk4(st2, on2, busy2, off2), {1'b0, 4'b0001, 3'b010});
    wait_cyc(24); chk("d2_pre1",   pk4(st2, on2, busy2, off2), {1'b0, 4'b0001, 3'b010});
    wait_cyc(25); chk("d2_ch1",    pk4(st2, on2, busy2, off2), {1'b0, 4'b0011, 3'b010});
    wait_cyc(26); chk("d2_zero",   pk4(st2, on2, busy2, off2), {1'b0, 4'b0111, 3'b010});
    wait_cyc(35); chk("d2_pre3",   pk4(st2, on2, busy2, off2), {1'b0, 4'b0111, 3'b010});
    wait_cyc(36); chk("d2_run",    pk4(st2, on2, busy2, off2), {1'b0, 4'b1111, 3'b100});
    wait_cyc(39); restart2 = 1'b1;
    wait_cyc(40); restart2 = 1'b0;
    chk("d2_rst_run", pk4(st2, on2, busy2, off2), {1'b0, 4'b1111, 3'b100});
    wait_cyc(44); stop2 = 1'b1;
    wait_cyc(45); stop2 = 1'b0; restart2 = 1'b1;
    chk("d2_stop",    pk4(st2, on2, busy2, off2), {1'b0, 4'b0111, 3'b010});
    wait_cyc(46); restart2 = 1'b0;
    chk("d2_rst_stp", pk4(st2, on2, busy2, off2), {1'b0, 4'b0111, 3'b010});
    wait_cyc(48); chk("d2_drop2",  pk4(st2, on2, busy2, off2), {1'b0, 4'b0011, 3'b010});
    wait_cyc(49); chk("d1_pre0",   {3'b000, st1, on1, busy1, off1}, 8'b0000_0010);
    wait_cyc(50);
    chk("d1_ch0",   {3'b000, st1, on1, busy1, off1}, 8'b0000_1010);
    chk("m_ch0",    pk4(st0, on0, busy0, off0), {1'b0, 4'b0001, 3'b010});
    wait_cyc(51); chk("d2_drop1",  pk4(st2, on2, busy2, off2), {1'b0, 4'b0001, 3'b010});
    wait_cyc(54); chk("d2_off",    pk4(st2, on2, busy2, off2), {1'b0, 4'b0000, 3'b001});
    wait_cyc(249); chk("d1_pre1",  {3'b000, st1, on1, busy1, off1}, 8'b0000_1010);
    wait_cyc(250);
    chk("d1_run",   {3'b000, st1, on1, busy1, off1}, 8'b0001_1100);
    chk("m_ch1",    pk4(st0, on0, busy0, off0), {1'b0, 4'b0011, 3'b010});
    wait_cyc(350); chk("m_ch2",    pk4(st0, on0, busy0, off0), {1'b0, 4'b0111, 3'b010});
    wait_cyc(450); chk("m_run",    pk4(st0, on0, busy0, off0), {1'b0, 4'b1111, 3'b100});

    wait_cyc(469); restart0 = 1'b1;
    wait_cyc(470); restart0 = 1'b0;
    wait_cyc(479); stop0 = 1'b1;
    wait_cyc(480); stop0 = 1'b0;
    chk("m_stop",   pk4(st0, on0, busy0, off0), {1'b0, 4'b0111, 3'b010});
    wait_cyc(489); restart0 = 1'b1;
    wait_cyc(490); restart0 = 1'b0;
    wait_cyc(505); chk("m_gap1",   pk4(st0, on0, busy0, off0), {1'b0, 4'b0011, 3'b010});
    wait_cyc(554); chk("m_gap2",   pk4(st0, on0, busy0, off0), {1'b0, 4'b0001, 3'b010});
    wait_cyc(555); chk("m_off",    pk4(st0, on0, busy0, off0), {1'b0, 4'b0000, 3'b001});

    wait_cyc(579); stop0 = 1'b1;
    wait_cyc(580); stop0 = 1'b0;
    wait_cyc(599); stop0 = 1'b1; restart0 = 1'b1;
    wait_cyc(600); stop0 = 1'b0; restart0 = 1'b0;
    wait_cyc(649); chk("m_rs_pre", pk4(st0, on0, busy0, off0), {1'b0, 4'b0000, 3'b010});
    wait_cyc(650); chk("m_rs_ch0", pk4(st0, on0, busy0, off0), {1'b0, 4'b0001, 3'b010});
    wait_cyc(719); stop0 = 1'b1;
    wait_cyc(720); stop0 = 1'b0;
    chk("m_stop_w", pk4(st0, on0, busy0, off0), {1'b0, 4'b0000, 3'b001});
    wait_cyc(759); restart0 = 1'b1;
    wait_cyc(760); restart0 = 1'b0;
    wait_cyc(1120); chk("m_pre_rst", pk4(st0, on0, busy0, off0), {1'b0, 4'b0111, 3'b010});

    #2 rst_n = 1'b0;
    #1 chk("async_drop", {4'b0000, st0}, 8'b0000_0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(19); stop0 = 1'b1;
    wait_cyc(20); stop0 = 1'b0;
    chk("m_stop_i0", pk4(st0, on0, busy0, off0), {1'b0, 4'b0000, 3'b001});
    wait_cyc(60); chk("m_idle",    pk4(st0, on0, busy0, off0), {1'b0, 4'b0000, 3'b001});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
